// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Parity insertion is controlled by the UART_TX_PARITY_EN macro in uart_tx_param.
package uart_pkg;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic STOP_LEVEL = 1'b1;

    function automatic int unsigned frame_bits(
        input int unsigned data_bits,
        input int unsigned stop_bits,
        input bit          parity_en
    );
        return 32'd1 + data_bits + (parity_en ? 32'd1 : 32'd0) + stop_bits;
    endfunction

    // Data is zero-extended to 16 bits, which leaves the reduction XOR unchanged.
    function automatic logic parity_bit(input logic [15:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic i_Clock,
    input  logic i_Rst_L,
    input  logic clear_s,
    output logic tick_s
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Free-running bit timer, held at zero while cleared.
    always_ff @(posedge i_Clock or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear_s || (cnt_r == CNT_LAST)) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick_s = (cnt_r == CNT_LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with valid/ready input and a one-word holding register.
// Define UART_TX_PARITY_EN to insert a parity bit between the data and stop bits.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_L,
    input  logic                 i_TX_DV,
    input  logic [DATA_BITS-1:0] i_TX_Data,
    output logic                 o_TX_Ready,
    output logic                 o_TX_Active,
    output logic                 o_TX_Serial,
    output logic                 o_TX_Done
);

    localparam int IDX_W = $clog2(DATA_BITS) + 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_e            state_r;
    tx_state_e            state_next_s;
    logic                 tick_s;
    logic                 clear_s;
    logic                 accept_s;
    logic                 load_s;
    logic                 frame_end_s;
    logic                 serial_next_s;
    logic                 ready_r;
    logic [DATA_BITS-1:0] holding_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [IDX_W-1:0]     bit_idx_r;
    logic                 stop_cnt_r;
    logic                 parity_r;
    logic                 serial_r;
    logic                 active_r;
    logic                 done_r;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .i_Clock(i_Clock),
        .i_Rst_L(i_Rst_L),
        .clear_s(clear_s),
        .tick_s (tick_s)
    );

    assign accept_s    = i_TX_DV && ready_r;
    assign clear_s     = (state_r == TX_IDLE);
    assign frame_end_s = (state_r == TX_STOP) && tick_s && (stop_cnt_r == STOP_LAST);

    // State register.
    always_ff @(posedge i_Clock or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            state_r <= TX_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, holding-to-shift load and next line level.
    always_comb begin
        state_next_s  = state_r;
        serial_next_s = IDLE_LEVEL;
        load_s        = 1'b0;
        case (state_r)
            TX_IDLE: begin
                serial_next_s = IDLE_LEVEL;
                if (!ready_r) begin
                    state_next_s = TX_START;
                    load_s       = 1'b1;
                end else begin
                    state_next_s = TX_IDLE;
                end
            end
            TX_START: begin
                serial_next_s = 1'b0;
                if (tick_s) begin
                    state_next_s = TX_DATA;
                end else begin
                    state_next_s = TX_START;
                end
            end
            TX_DATA: begin
                serial_next_s = shift_r[0];
                if (tick_s && (bit_idx_r == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
                    state_next_s = TX_PARITY;
`else
                    state_next_s = TX_STOP;
`endif
                end else begin
                    state_next_s = TX_DATA;
                end
            end
            TX_PARITY: begin
                serial_next_s = parity_r;
                if (tick_s) begin
                    state_next_s = TX_STOP;
                end else begin
                    state_next_s = TX_PARITY;
                end
            end
            TX_STOP: begin
                serial_next_s = STOP_LEVEL;
                if (frame_end_s && !ready_r) begin
                    state_next_s = TX_START;
                    load_s       = 1'b1;
                end else if (frame_end_s) begin
                    state_next_s = TX_IDLE;
                end else begin
                    state_next_s = TX_STOP;
                end
            end
            default: begin
                state_next_s  = TX_IDLE;
                serial_next_s = IDLE_LEVEL;
            end
        endcase
    end

    // Holding register; a new accept wins over a same-cycle load so the new word stays pending.
    always_ff @(posedge i_Clock or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            ready_r   <= 1'b1;
            holding_r <= {DATA_BITS{1'b0}};
        end else if (accept_s) begin
            ready_r   <= 1'b0;
            holding_r <= i_TX_Data;
        end else if (load_s) begin
            ready_r   <= 1'b1;
        end else begin
            ready_r   <= ready_r;
        end
    end

    // Shift register, data bit index, stop-bit count and latched parity.
    always_ff @(posedge i_Clock or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            shift_r    <= {DATA_BITS{1'b0}};
            bit_idx_r  <= {IDX_W{1'b0}};
            stop_cnt_r <= 1'b0;
            parity_r   <= 1'b0;
        end else if (load_s) begin
            shift_r    <= holding_r;
            bit_idx_r  <= {IDX_W{1'b0}};
            stop_cnt_r <= 1'b0;
            parity_r   <= parity_bit(16'(holding_r), 1'(PARITY_ODD));
        end else if ((state_r == TX_DATA) && tick_s) begin
            shift_r    <= {1'b0, shift_r[DATA_BITS-1:1]};
            bit_idx_r  <= (bit_idx_r == IDX_LAST) ? {IDX_W{1'b0}} : bit_idx_r + IDX_W'(1);
        end else if ((state_r == TX_STOP) && tick_s) begin
            stop_cnt_r <= frame_end_s ? 1'b0 : stop_cnt_r + 1'b1;
        end else begin
            stop_cnt_r <= stop_cnt_r;
        end
    end

    // Line-side outputs trail the state by one cycle so all three stay mutually aligned.
    always_ff @(posedge i_Clock or posedge i_Rst_L) begin
        if (i_Rst_L) begin
            serial_r <= IDLE_LEVEL;
            active_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            serial_r <= serial_next_s;
            active_r <= (state_r != TX_IDLE);
            done_r   <= frame_end_s;
        end
    end

    assign o_TX_Ready  = ready_r;
    assign o_TX_Active = active_r;
    assign o_TX_Serial = serial_r;
    assign o_TX_Done   = done_r;

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter; successor to the fixed 8N1 transmitter.
- Adds configurable data width, 1 or 2 stop bits, optional parity, and a valid/ready input handshake.
- A one-entry holding register lets frames go out back-to-back with no idle gap.
- Sits between the system-side byte/word producer and the board TX pin.

Parameters:
- CLKS_PER_BIT, 10417, i_Clock cycles per serial bit (>=2); e.g. 100 MHz / 9600 baud.
- DATA_BITS, 8, data bits per frame, legal 5..16.
- STOP_BITS, 1, stop bits per frame, legal 1 or 2.
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; only used when UART_TX_PARITY_EN is defined.

Ports:
- i_Clock  in  1  system clock.
- i_Rst_L  in  1  reset, asynchronous, active-high.
- i_TX_DV  in  1  data valid; word accepted on a rising edge where i_TX_DV && o_TX_Ready.
- i_TX_Data  in  DATA_BITS  word to send, LSB first.
- o_TX_Ready  out  1  holding register empty; may accept a word.
- o_TX_Active  out  1  high from first start-bit cycle to last stop-bit cycle of a burst.
- o_TX_Serial  out  1  serial line; idle high.
- o_TX_Done  out  1  one-cycle pulse in the last cycle of each frame's final stop bit.

Behaviour:
- Reset values (asynchronous on i_Rst_L=1):
  - o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1.
  - State IDLE; counters 0; holding register empty.
- Reset mid-frame: line returns high immediately, the frame and any held word are discarded, and no Done pulse is issued.
- States:
  - IDLE, START, DATA, PARITY, STOP.
  - Each bit is held for exactly CLKS_PER_BIT cycles, counted by a bit-timer that wraps 0..CLKS_PER_BIT-1.
- Transitions:
  - IDLE->START when holding valid.
  - START->DATA when the bit-timer wraps.
  - DATA advances the bit index 0..DATA_BITS-1, then goes to PARITY (macro on) or STOP.
  - PARITY->STOP.
  - STOP counts STOP_BITS bit periods, then returns to START if holding valid, else IDLE.
- Handshake:
  - o_TX_Ready = !holding_valid.
  - On acceptance, the word is written to holding and Ready drops the next cycle.
  - The word moves from holding to the shift register on entry to START; holding empties and Ready rises the same cycle.
  - i_TX_Data is ignored when not accepted.
- Latency:
  - A word accepted at edge N in IDLE drives o_TX_Serial=0 from edge N+2.
  - Frame length = CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS), with P=1 when parity is on.
- Back-to-back: if holding is valid at the end of STOP, the next START bit follows with zero idle cycles and o_TX_Active stays high.
- Simultaneous accept and load in the same cycle: holding is written with the new word and remains valid.
- Done and Active: o_TX_Done pulses once per frame; o_TX_Active falls the cycle after the final Done when no word is pending.
- Timer width: bit-timer is $clog2(CLKS_PER_BIT) bits; bit index is $clog2(DATA_BITS)+1 bits. No overflow permitted.

Optional Feature:
- UART_TX_PARITY_EN
  - Defined: the PARITY state is inserted after DATA and transmits the reduction XOR of the data word, inverted when PARITY_ODD=1. The frame grows by one bit.
  - Undefined: no PARITY state; DATA goes directly to STOP; PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg:
  - TX state enum (IDLE/START/DATA/PARITY/STOP encodings, 3 bits).
  - Localparams for idle and stop levels.
  - A function computing frame length in bits.
- Sub-module uart_baud_tick:
  - Parametrised by CLKS_PER_BIT.
  - Counter with sync clear, emitting a one-cycle tick at bit-period end.
  - The FSM consumes the tick and clears the counter on frame start.

Test Plan:
- CLKS_PER_BIT=4, 8N1, send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1 each held 4 cycles; Serial low 2 cycles after accept; one Done pulse at cycle 39 after start.
- Two words 0x3C then 0xC3 with DV held high -> second accepted while the first shifts, Ready low until first START; second start bit immediately follows first stop bit; Active high throughout; two Done pulses.
- UART_TX_PARITY_EN, PARITY_ODD=0, DATA_BITS=7, send 7'h55 -> parity bit 0; with PARITY_ODD=1 -> parity bit 1; frame 10 bits.
- STOP_BITS=2, DATA_BITS=5, send 5'h1F -> stop high for 8 cycles at CLKS_PER_BIT=4; Done only in the last stop cycle.
- Assert i_Rst_L during DATA bit 3 -> Serial=1, Active=0, Ready=1 asynchronously; no Done; next word after release transmits a clean frame.
- DV pulsed while Ready=0 -> word ignored; only previously accepted words appear on the line.
